muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. 32-step shift-add
//               multiply and restoring divide on magnitudes, with the
//               divide-by-zero and signed-overflow cases resolved in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [XLEN-1:0] c_MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_ONES    = {XLEN{1'b1}};

    logic [1:0]      r_state, w_next_state;
    logic [4:0]      r_cnt;
    logic [2:0]      r_op;
    logic            r_neg_a, r_neg_b;
    logic [XLEN-1:0] r_hi, r_lo, r_opnd, r_result;

    // ---------------- accept-time operand decode ----------------
    logic            w_accept, w_a_signed, w_b_signed, w_sa, w_sb;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_div_zero, w_ovf, w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_accept   = start && (r_state != c_CALC);
    assign w_a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign w_b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign w_sa       = w_a_signed & SrcA[XLEN-1];
    assign w_sb       = w_b_signed & SrcB[XLEN-1];
    assign w_mag_a    = w_sa ? (~SrcA + 1'b1) : SrcA;
    assign w_mag_b    = w_sb ? (~SrcB + 1'b1) : SrcB;

    assign w_div_zero = funct3[2] && (SrcB == '0);
    assign w_ovf      = funct3[2] && !funct3[0] && (SrcA == c_MIN_INT) && (SrcB == c_ONES);
    assign w_special  = w_div_zero || w_ovf;
    // Divide-by-zero takes priority; REM* returns the dividend, DIV* all ones.
    assign w_special_res = w_div_zero ? (funct3[1] ? SrcA : c_ONES)
                                      : (funct3[1] ? '0   : c_MIN_INT);

    // ---------------- one iteration step ----------------
    // Multiply: {r_hi,r_lo} is the product/multiplier pair, shifted right.
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN-1:0] w_mul_hi, w_mul_lo;
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_hi  = w_mul_sum[XLEN:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[XLEN-1:1]};

    // Divide: r_hi is the partial remainder, r_lo shifts dividend out, quotient in.
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_sub, w_div_hi, w_div_lo;
    logic            w_ge;
    assign w_shift  = {r_hi, r_lo[XLEN-1]};
    assign w_ge     = (w_shift >= {1'b0, r_opnd});
    assign w_sub    = w_shift[XLEN-1:0] - r_opnd;
    assign w_div_hi = w_ge ? w_sub : w_shift[XLEN-1:0];
    assign w_div_lo = {r_lo[XLEN-2:0], w_ge};

    logic [XLEN-1:0] w_nhi, w_nlo;
    assign w_nhi = r_op[2] ? w_div_hi : w_mul_hi;
    assign w_nlo = r_op[2] ? w_div_lo : w_mul_lo;

    // ---------------- sign correction of the final step ----------------
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_quo_s, w_rem_s, w_final;
    assign w_prod   = {w_nhi, w_nlo};
    assign w_prod_s = (r_neg_a ^ r_neg_b) ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_s  = (r_neg_a ^ r_neg_b) ? (~w_nlo + 1'b1) : w_nlo;
    assign w_rem_s  = r_neg_a ? (~w_nhi + 1'b1) : w_nhi;

    always_comb begin
        w_final = w_prod_s[2*XLEN-1:XLEN];
        case (r_op)
            3'b000:         w_final = w_prod_s[XLEN-1:0];
            3'b100, 3'b101: w_final = w_quo_s;
            3'b110, 3'b111: w_final = w_rem_s;
            default:        w_final = w_prod_s[2*XLEN-1:XLEN];
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) w_next_state = w_special ? c_DONE : c_CALC;
                else       w_next_state = c_IDLE;
            end
            c_CALC:  if (r_cnt == 5'd31) w_next_state = c_DONE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= funct3;
            r_neg_a <= w_sa;
            r_neg_b <= w_sb;
            r_hi    <= '0;
            // Multiply: A is the multiplicand, B shifts through r_lo.
            // Divide:   A (dividend) shifts through r_lo, B is the divisor.
            r_lo    <= funct3[2] ? w_mag_a : w_mag_b;
            r_opnd  <= funct3[2] ? w_mag_b : w_mag_a;
            if (w_special) r_result <= w_special_res;
        end else if (r_state == c_CALC) begin
            r_cnt <= r_cnt + 5'd1;
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
            if (r_cnt == 5'd31) r_result <= w_final;
        end
    end

    assign busy   = (r_state == c_CALC);
    assign done   = (r_state == c_DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] SrcA, SrcB;
    logic        busy, done;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.XLEN(32)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request and let it be sampled by one rising edge.
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3 = f; SrcA = a; SrcB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges from the start edge (inclusive) until done is seen.
    // Optionally pulses a conflicting request at a given cycle.
    task automatic wait_done(input int pulse_at, output int lat, output int bcnt);
        lat = 1; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            if (lat == pulse_at) begin
                start = 1'b1; funct3 = 3'b011; SrcA = 32'd3; SrcB = 32'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat, bcnt;
        launch(f, a, b);
        wait_done(-1, lat, bcnt);
        check({tag, " result"}, result, exp);
        check({tag, " latency"}, lat, exp_lat);
    endtask

    initial begin
        int lat, bcnt, ndone;
        rst = 1'b1; start = 1'b0; funct3 = 3'b000; SrcA = '0; SrcB = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", result, 32'h0);
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // MUL -3*7 with latency and busy duration
        launch(3'b000, 32'hFFFF_FFFD, 32'd7);
        wait_done(-1, lat, bcnt);
        check("mul result", result, 32'hFFFF_FFEB);
        check("mul latency", lat, 33);
        check("mul busy cycles", bcnt, 32);

        // High-half multiplies of all-ones operands, back-to-back
        run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("mul zero", 3'b000, 32'h0, 32'h1234_5678, 32'h0, 33);

        // Divide / remainder sign handling
        run_op("div -7/2",   3'b100, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD, 33);
        run_op("rem -7/2",   3'b110, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 33);
        run_op("divu",       3'b101, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33);
        run_op("div 100/-7", 3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
        run_op("rem 100/-7", 3'b110, 32'd100, 32'hFFFF_FFF9, 32'd2, 33);
        run_op("remu",       3'b111, 32'd100, 32'd7, 32'd2, 33);

        // Single-cycle special cases
        run_op("div by 0",  3'b100, 32'd42, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem by 0",  3'b110, 32'd42, 32'd0, 32'd42, 1);
        run_op("remu by 0", 3'b111, 32'd42, 32'd0, 32'd42, 1);
        run_op("div ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        // Conflicting start in CALC is ignored
        launch(3'b000, 32'd1000, 32'd1000);
        wait_done(10, lat, bcnt);
        check("ignore start result", result, 32'h000F_4240);
        check("ignore start latency", lat, 33);

        // start held during DONE launches the next op with no bubble
        launch(3'b101, 32'd1000, 32'd3);
        check("b2b busy", {31'b0, busy}, 32'h1);
        check("b2b result held", result, 32'h000F_4240);
        wait_done(-1, lat, bcnt);
        check("b2b result", result, 32'd333);
        check("b2b latency", lat, 33);
        @(posedge clk); #1;
        check("done one cycle", {31'b0, done}, 32'h0);

        // Reset mid-CALC aborts; start during reset is ignored
        launch(3'b000, 32'd1000, 32'd1000);
        repeat (14) @(posedge clk);
        #1;
        check("pre-reset busy", {31'b0, busy}, 32'h1);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("abort busy", {31'b0, busy}, 32'h0);
        check("abort result", result, 32'h0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) ndone++;
            @(posedge clk); #1;
        end
        check("abort no activity", ndone, 0);
        run_op("mulhu after rst", 3'b011, 32'd5, 32'd5, 32'h0, 33);
        run_op("mul after rst",   3'b000, 32'd5, 32'd5, 32'd25, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
